adc_axi_regbank: RTL

- Parametrised AXI4-Lite register bank for the multi-channel ADC path: NUM_CH live sample registers, per-channel gain/offset, global acquisition settings, control pulses, sticky status.
- Sits between the PS AXI interconnect and the ADC capture/DDR-store logic.
- Adds independent AW/W acceptance, error responses, value clamping, W1C status and self-clearing start.

---
 rtl/adc_regbank_pkg.sv | 64 ++++++
 rtl/adc_ch_regs.sv | 40 ++++
 rtl/adc_axi_regbank.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/adc_regbank_pkg.sv
// Shared definitions for the ADC AXI4-Lite register bank.
// - Register byte offsets, CTRL/STATUS bit positions, AXI response codes.
// - Address decode result struct and decode helper.
// - Byte-strobe merge helper used by every RW register.
package adc_regbank_pkg;

  localparam logic [31:0] OFF_CTRL    = 32'h00;
  localparam logic [31:0] OFF_STATUS  = 32'h04;
  localparam logic [31:0] OFF_FREQ    = 32'h08;
  localparam logic [31:0] OFF_DDR     = 32'h0C;
  localparam logic [31:0] OFF_CH_BASE = 32'h10;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ENABLE = 1;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_OVR    = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int FREQ_MIN_DEF = 240;

  // Register slot inside one 16-byte channel window.
  typedef enum logic [1:0] {CH_DATA = 2'd0, CH_GAIN = 2'd1, CH_OFFSET = 2'd2, CH_RSVD = 2'd3} ch_reg_e;

  typedef struct packed {
    logic    ctrl;
    logic    status;
    logic    freq;
    logic    ddr;
    logic    chan;
    logic [2:0] ch;
    ch_reg_e sub;
  } addr_dec_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] cur, input logic [31:0] wdat,
                                             input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) res[8*b +: 8] = strb[b] ? wdat[8*b +: 8] : cur[8*b +: 8];
    return res;
  endfunction

  // Low two address bits are ignored; channel windows beyond num_ch decode as unmapped.
  function automatic addr_dec_t addr_decode(input logic [31:0] addr, input int unsigned num_ch);
    logic [31:0] w, rel;
    addr_dec_t d;
    w   = addr & ~32'h3;
    rel = w - OFF_CH_BASE;
    d   = '0;
    case (w)
      OFF_CTRL:   d.ctrl   = 1'b1;
      OFF_STATUS: d.status = 1'b1;
      OFF_FREQ:   d.freq   = 1'b1;
      OFF_DDR:    d.ddr    = 1'b1;
      default: if (w >= OFF_CH_BASE && (rel >> 4) < num_ch) begin
        d.chan = 1'b1;
        d.ch   = rel[6:4];
        d.sub  = ch_reg_e'(rel[3:2]);
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/adc_ch_regs.sv
// One ADC channel's registers.
// - data   : live sample, loaded on adc_valid.
// - gain   : RW, byte-strobed.
// - offset : RW, byte-strobed.
// - ovr    : sticky overrange flag, set by ovr_pulse, cleared by ovr_clr (set wins).
module adc_ch_regs
  import adc_regbank_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] adc_data,
  input  logic        adc_valid,
  input  logic        ovr_pulse,
  input  logic        wr_gain,
  input  logic        wr_offset,
  input  logic        ovr_clr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] data,
  output logic [31:0] gain,
  output logic [31:0] offset,
  output logic        ovr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data   <= '0;
      gain   <= '0;
      offset <= '0;
      ovr    <= 1'b0;
    end else begin
      if (adc_valid) data   <= adc_data;
      if (wr_gain)   gain   <= strb_merge(gain, wdata, wstrb);
      if (wr_offset) offset <= strb_merge(offset, wdata, wstrb);
      if (ovr_pulse)    ovr <= 1'b1;
      else if (ovr_clr) ovr <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_axi_regbank.sv
// AXI4-Lite register bank for the multi-channel ADC path.
// - S_AXI_*      : AXI4-Lite slave (AW/W accepted independently, one write in flight).
// - i_adc_data/i_adc_valid : live per-channel samples into DATA registers.
// - i_ovr        : per-channel overrange pulses into sticky STATUS flags.
// - i_busy       : capture engine busy; blocks START and shows in STATUS.
// - o_user_gain/o_user_offset/o_adc_freq/o_ddr_size/o_enable : registered copies
//   of the register contents; o_start : one-cycle start pulse.
module adc_axi_regbank
  import adc_regbank_pkg::*;
#(
  parameter int NUM_CH             = 4,
  parameter int MEM_SIZE           = 10000,
  parameter int FREQ_MIN           = FREQ_MIN_DEF,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  localparam int DW                = $clog2(MEM_SIZE) + 1
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [NUM_CH*32-1:0]            i_adc_data,
  input  logic [NUM_CH-1:0]               i_adc_valid,
  input  logic [NUM_CH-1:0]               i_ovr,
  input  logic                            i_busy,
  output logic [NUM_CH*32-1:0]            o_user_gain,
  output logic [NUM_CH*32-1:0]            o_user_offset,
  output logic [9:0]                      o_adc_freq,
  output logic [DW-1:0]                   o_ddr_size,
  output logic                            o_enable,
  output logic                            o_start
);

  logic                          aw_held, w_held, wr_fire;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [31:0]                   w_data;
  logic [3:0]                    w_strb;
  addr_dec_t                     wd, rd;
  logic                          wr_err, rd_err;
  logic [31:0]                   rd_data;

  logic          enable, start_q;
  logic [9:0]    freq, freq_m;
  logic [DW-1:0] ddr;
  logic [31:0]   ddr_m;

  logic [NUM_CH-1:0][31:0] ch_data, ch_gain, ch_offset;
  logic [NUM_CH-1:0]       ch_ovr, wr_gain, wr_offset, ovr_clr;

  assign wd      = addr_decode(32'(aw_addr), NUM_CH);
  assign rd      = addr_decode(32'(S_AXI_ARADDR), NUM_CH);
  // Both halves captured and no response pending: commit this cycle.
  assign wr_fire = aw_held & w_held;
  assign wr_err  = ~(wd.ctrl | wd.status | wd.freq | wd.ddr | (wd.chan & (wd.sub != CH_DATA)));

  // Clamps act on the strobe-merged value, not on raw WDATA.
  assign freq_m = {w_strb[1] ? w_data[9:8] : freq[9:8], w_strb[0] ? w_data[7:0] : freq[7:0]};
  assign ddr_m  = strb_merge(32'(ddr), w_data, w_strb);

  // ---------------- write channel ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
    end else begin
      S_AXI_AWREADY <= ~S_AXI_AWREADY & S_AXI_AWVALID & ~aw_held & ~S_AXI_BVALID;
      S_AXI_WREADY  <= ~S_AXI_WREADY & S_AXI_WVALID & ~w_held & ~S_AXI_BVALID;
      if (S_AXI_AWREADY && S_AXI_AWVALID) begin
        aw_held <= 1'b1;
        aw_addr <= S_AXI_AWADDR;
      end
      if (S_AXI_WREADY && S_AXI_WVALID) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (wr_fire) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // ---------------- global registers + output copies ----------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      enable        <= 1'b0;
      start_q       <= 1'b0;
      freq          <= 10'(FREQ_MIN);
      ddr           <= DW'(MEM_SIZE);
      o_enable      <= 1'b0;
      o_start       <= 1'b0;
      o_adc_freq    <= 10'(FREQ_MIN);
      o_ddr_size    <= DW'(MEM_SIZE);
      o_user_gain   <= '0;
      o_user_offset <= '0;
    end else begin
      start_q <= wr_fire & wd.ctrl & w_strb[0] & w_data[CTRL_START] & ~i_busy;
      if (wr_fire && wd.ctrl && w_strb[0]) enable <= w_data[CTRL_ENABLE];
      if (wr_fire && wd.freq) freq <= (freq_m < 10'(FREQ_MIN)) ? 10'(FREQ_MIN) : freq_m;
      if (wr_fire && wd.ddr) begin
        if (ddr_m > 32'(MEM_SIZE)) ddr <= DW'(MEM_SIZE);
        else if (ddr_m == '0)      ddr <= DW'(1);
        else                       ddr <= ddr_m[DW-1:0];
      end
      o_enable   <= enable;
      o_start    <= start_q;
      o_adc_freq <= freq;
      o_ddr_size <= ddr;
      for (int k = 0; k < NUM_CH; k++) begin
        o_user_gain[32*k +: 32]   <= ch_gain[k];
        o_user_offset[32*k +: 32] <= ch_offset[k];
      end
    end
  end

  // ---------------- per-channel registers ----------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign wr_gain[k]   = wr_fire & wd.chan & (wd.ch == 3'(k)) & (wd.sub == CH_GAIN);
    assign wr_offset[k] = wr_fire & wd.chan & (wd.ch == 3'(k)) & (wd.sub == CH_OFFSET);
    assign ovr_clr[k]   = wr_fire & wd.status & w_strb[1] & w_data[STAT_OVR+k];

    adc_ch_regs u_ch (
      .clk       (S_AXI_ACLK),
      .rst_n     (S_AXI_ARESETN),
      .adc_data  (i_adc_data[32*k +: 32]),
      .adc_valid (i_adc_valid[k]),
      .ovr_pulse (i_ovr[k]),
      .wr_gain   (wr_gain[k]),
      .wr_offset (wr_offset[k]),
      .ovr_clr   (ovr_clr[k]),
      .wdata     (w_data),
      .wstrb     (w_strb),
      .data      (ch_data[k]),
      .gain      (ch_gain[k]),
      .offset    (ch_offset[k]),
      .ovr       (ch_ovr[k])
    );
  end

  // ---------------- read channel ----------------
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (rd.ctrl) begin
      rd_data[CTRL_ENABLE] = enable;
    end else if (rd.status) begin
      rd_data[STAT_BUSY]           = i_busy;
      rd_data[STAT_OVR +: NUM_CH]  = ch_ovr;
    end else if (rd.freq) begin
      rd_data[9:0] = freq;
    end else if (rd.ddr) begin
      rd_data[DW-1:0] = ddr;
    end else if (rd.chan) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (rd.ch == 3'(k)) begin
          case (rd.sub)
            CH_DATA:   rd_data = ch_data[k];
            CH_GAIN:   rd_data = ch_gain[k];
            CH_OFFSET: rd_data = ch_offset[k];
            default:   rd_data = '0;
          endcase
        end
      end
    end else begin
      rd_err = 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      S_AXI_ARREADY <= ~S_AXI_ARREADY & S_AXI_ARVALID & ~S_AXI_RVALID;
      if (S_AXI_ARREADY && S_AXI_ARVALID) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_data;
        S_AXI_RRESP  <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

endmodule
